// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use/branch hazard control, debug halt/step drain FSM, event counters
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             resume_req,
  input  logic             cnt_clear,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2,
    STEP   = 3'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          lu_raw;
  logic          active;
  logic          br;
  logic          lu;

  // X31 reads as zero, so a load targeting it can never feed a consumer.
  assign lu_raw = ex_mem_read && (ex_rd != 5'd31) &&
                  ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

  // Hazards are only acted on while instructions are still flowing; HALTED and
  // STEP run on an already-empty pipeline.
  assign active = (state == RUN) || (state == DRAIN);
  assign br     = mem_branch_taken && active;
  assign lu     = lu_raw && !mem_branch_taken && active;

  assign halted  = (state == HALTED);
  assign state_o = state;

  // Per-state pipeline register enables and flushes, branch before load-use.
  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    case (state)
      RUN, DRAIN: begin
        if (br) begin
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
          if_id_flush    = 1'b1;
          id_ex_flush    = 1'b1;
          ex_mem_flush   = 1'b1;
        end else if (lu) begin
          id_ex_flush = 1'b1;
        end else if (state == RUN) begin
          pc_write_en    = 1'b1;
          if_id_write_en = 1'b1;
        end else begin
          if_id_write_en = 1'b1;
          if_id_flush    = 1'b1;
        end
      end
      HALTED: begin
        if_id_flush = 1'b1;
      end
      STEP: begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
      default: begin
        pc_write_en = 1'b0;
      end
    endcase
  end

  // Debug sequencing FSM; any hazard during drain restarts the bubble count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          if (br || lu) begin
            drain_cnt <= DW'(DRAIN_CYCLES);
          end else if (drain_cnt == DW'(1)) begin
            state     <= HALTED;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: begin
          if (resume_req) begin
            state <= RUN;
          end else if (step_req) begin
            state <= STEP;
          end
        end
        STEP: begin
          state     <= DRAIN;
          drain_cnt <= DW'(DRAIN_CYCLES);
        end
        default: begin
          state     <= RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating event counters; clear takes precedence over a same-cycle event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clear) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (lu && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (br && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequencing controller for the 5-stage pipelined core (IF, ID, EX, MEM, WB). It detects load-use hazards and inserts one bubble. It flushes the three younger stages when a branch resolves taken in MEM. It also provides a debug halt/step/resume sequence that drains the pipeline before reporting halted. It drives write-enables and flushes for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers, and keeps saturating event counters.

Parameters:
DRAIN_CYCLES, 4, cycles of bubble injection needed to empty ID..WB after fetch stops
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
id_rn  input  5  ID-stage Rn field (instruction bits 9:5)
id_rm  input  5  ID-stage second read register (output of the reg_to_loc mux)
id_uses_rm  input  1  ID instruction reads the second register
ex_mem_read  input  1  EX-stage instruction is a load
ex_rd  input  5  EX-stage destination register (bits 4:0)
mem_branch_taken  input  1  branch AND zero, resolved in MEM
halt_req  input  1  debug: stop and drain
step_req  input  1  debug: execute one instruction while halted
resume_req  input  1  debug: return to RUN
cnt_clear  input  1  synchronous clear of both counters
pc_write_en  output  1  PC may load next PC
if_id_write_en  output  1  IF/ID register may capture
if_id_flush  output  1  load a bubble into IF/ID
id_ex_flush  output  1  load a bubble (all control bits 0) into ID/EX
ex_mem_flush  output  1  load a bubble into EX/MEM
halted  output  1  pipeline empty and frozen
state_o  output  3  current FSM state, for debug
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- Reset forces state RUN, drain counter 0 and both counters 0.
- With hazard inputs low in RUN, outputs are: pc_write_en=1, if_id_write_en=1, all flushes 0, halted=0.
- Hazard decode is combinational in the same cycle. State, counters and the drain counter are registered.
- Load-use (lu): ex_mem_read=1 AND ex_rd!=31 AND (ex_rd==id_rn OR (id_uses_rm AND ex_rd==id_rm)).
  - Response: pc_write_en=0, if_id_write_en=0, id_ex_flush=1.
  - Lasts exactly one cycle, because the bubble removes the load from EX.
- Taken branch (br): mem_branch_taken=1.
  - Response: if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write_en=1 so the target loads.
  - br has priority over lu in the same cycle. lu is suppressed and stall_count does not increment.
- X31 (XZR) never creates a hazard.
- FSM states:
  - RUN: normal operation. halt_req goes to DRAIN with drain_cnt=DRAIN_CYCLES.
  - DRAIN: pc_write_en=0 unless br; if_id_flush=1 (bubbles enter).
    - Each cycle without lu, drain_cnt decrements.
    - lu holds IF/ID (if_id_write_en=0, id_ex_flush=1, no if_id_flush) and reloads drain_cnt=DRAIN_CYCLES.
    - br flushes as in RUN and reloads drain_cnt=DRAIN_CYCLES.
    - drain_cnt==1 with no lu/br goes to HALTED.
  - HALTED: pc_write_en=0, if_id_write_en=0, if_id_flush=1, halted=1.
    - resume_req goes to RUN.
    - Else step_req goes to STEP.
    - resume_req has priority over step_req.
  - STEP: exactly one cycle with pc_write_en=1, if_id_write_en=1 and no flush, then DRAIN with drain_cnt=DRAIN_CYCLES.
- halt_req in DRAIN, HALTED or STEP is ignored.
- resume_req outside HALTED is ignored.
- Requests are level-sampled each cycle. No acknowledge is given beyond halted and state_o.
- Counters:
  - stall_count increments on each cycle where lu is acted on, in any state.
  - flush_count increments on each br cycle.
  - Both saturate at 2^CNT_W-1.
  - cnt_clear wins over an increment in the same cycle.
- reset_n low mid-DRAIN or mid-STEP returns immediately to RUN with counters 0.

Test Plan:
- LDUR X2 in EX (ex_mem_read=1, ex_rd=2), ID ADD with id_rn=2 -> one cycle with pc_write_en=0, if_id_write_en=0, id_ex_flush=1; next cycle normal; stall_count=1.
- Same stimulus with ex_rd=31, or with id_uses_rm=0 and id_rm=2 -> no stall; stall_count stays 0.
- mem_branch_taken=1 together with an lu condition -> all three flushes=1, pc_write_en=1, stall_count unchanged, flush_count=1.
- halt_req pulse in RUN -> if_id_flush=1 for 4 cycles, halted=1 on cycle 5; lu injected on drain cycle 2 -> halted delayed to cycle 7.
- HALTED, step_req -> one cycle pc_write_en=1 and no flush, then 4 drain cycles, halted=1; step_req and resume_req together -> RUN.
- Drive 65536 lu cycles -> stall_count=0xFFFF held; cnt_clear -> 0; reset_n low during DRAIN -> state_o=RUN, counters 0 asynchronously.
